// File: rtl/vga_timing_if.sv
// Raster output bundle carried from the VGA timing generator to pixel generators.
// Latency: n/a (signal bundle only); master = timing generator, slave = pixel pipeline.
// Backpressure: none; the raster free-runs and consumers must keep up every pixel clock.
// Signals: hsync/vsync (sync pulses), de (visible region), x/y (raster position),
//          line_start/frame_start (one-cycle strobes at x==0 / x==0,y==0).
interface vga_timing_if #(
   parameter int CNT_W = 10
);
   logic             hsync;
   logic             vsync;
   logic             de;
   logic [CNT_W-1:0] x;
   logic [CNT_W-1:0] y;
   logic             line_start;
   logic             frame_start;

   modport master (
      output hsync, vsync, de, x, y, line_start, frame_start
   );

   modport slave (
      input  hsync, vsync, de, x, y, line_start, frame_start
   );
endinterface

// File: rtl/vga_timing.sv
// VGA raster generator: h/v counters plus registered sync, data-enable, coordinates and strobes.
// Latency: outputs lag the counters by one clock; first frame_start appears after the 3rd edge
//          following clk_ready rising. Backpressure: none, the raster free-runs once enabled.
// Ports: in_clk (pixel clock), rst_n (async active-low reset), clk_ready (async PLL lock),
//        vid (master side of vga_timing_if: hsync, vsync, de, x, y, line_start, frame_start).
module vga_timing #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int SYNC_POL = 0,
   parameter int CNT_W    = 10
) (
   input  logic         in_clk,
   input  logic         rst_n,
   input  logic         clk_ready,
   vga_timing_if.master vid
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

   // Window bounds carry one extra bit: the sync-end bound equals the total
   // when the back porch is zero, which may not fit in CNT_W bits.
   localparam logic [CNT_W:0] H_ACT_END  = (CNT_W+1)'(H_ACTIVE);
   localparam logic [CNT_W:0] V_ACT_END  = (CNT_W+1)'(V_ACTIVE);
   localparam logic [CNT_W:0] HS_BEG     = (CNT_W+1)'(H_ACTIVE + H_FP);
   localparam logic [CNT_W:0] HS_END     = (CNT_W+1)'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CNT_W:0] VS_BEG     = (CNT_W+1)'(V_ACTIVE + V_FP);
   localparam logic [CNT_W:0] VS_END     = (CNT_W+1)'(V_ACTIVE + V_FP + V_SYNC);

   localparam logic SYNC_ON  = (SYNC_POL != 0);
   localparam logic SYNC_OFF = ~SYNC_ON;

   logic             ready_meta;
   logic             enable;
   logic [CNT_W-1:0] h_cnt;
   logic [CNT_W-1:0] v_cnt;

   logic             hsync_r;
   logic             vsync_r;
   logic             de_r;
   logic [CNT_W-1:0] x_r;
   logic [CNT_W-1:0] y_r;
   logic             line_start_r;
   logic             frame_start_r;

   logic [CNT_W:0]   h_ext;
   logic [CNT_W:0]   v_ext;

   assign h_ext = {1'b0, h_cnt};
   assign v_ext = {1'b0, v_cnt};

   // Two-flop synchronizer for the PLL lock; reset clears it so that every
   // reset release goes through the full startup sequence again.
   always_ff @(posedge in_clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_meta <= 1'b0;
         enable     <= 1'b0;
      end else begin
         ready_meta <= clk_ready;
         enable     <= ready_meta;
      end
   end

   // Counters are held at the origin while disabled, so each enable period
   // begins with a complete frame from (0,0).
   always_ff @(posedge in_clk or negedge rst_n) begin
      if (!rst_n) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (!enable) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (h_cnt == H_LAST) begin
         h_cnt <= '0;
         v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CNT_W'(1);
      end else begin
         h_cnt <= h_cnt + CNT_W'(1);
      end
   end

   // Outputs are decoded from the current counter values and registered,
   // giving glitch-free syncs one clock behind the counters. vsync follows
   // v_cnt, which only changes at the line wrap, so it spans whole lines.
   always_ff @(posedge in_clk or negedge rst_n) begin
      if (!rst_n) begin
         hsync_r       <= SYNC_OFF;
         vsync_r       <= SYNC_OFF;
         de_r          <= 1'b0;
         x_r           <= '0;
         y_r           <= '0;
         line_start_r  <= 1'b0;
         frame_start_r <= 1'b0;
      end else if (!enable) begin
         hsync_r       <= SYNC_OFF;
         vsync_r       <= SYNC_OFF;
         de_r          <= 1'b0;
         x_r           <= '0;
         y_r           <= '0;
         line_start_r  <= 1'b0;
         frame_start_r <= 1'b0;
      end else begin
         x_r           <= h_cnt;
         y_r           <= v_cnt;
         de_r          <= (h_ext < H_ACT_END) && (v_ext < V_ACT_END);
         hsync_r       <= ((h_ext >= HS_BEG) && (h_ext < HS_END)) ? SYNC_ON : SYNC_OFF;
         vsync_r       <= ((v_ext >= VS_BEG) && (v_ext < VS_END)) ? SYNC_ON : SYNC_OFF;
         line_start_r  <= (h_cnt == '0);
         frame_start_r <= (h_cnt == '0) && (v_cnt == '0);
      end
   end

   assign vid.hsync       = hsync_r;
   assign vid.vsync       = vsync_r;
   assign vid.de          = de_r;
   assign vid.x           = x_r;
   assign vid.y           = y_r;
   assign vid.line_start  = line_start_r;
   assign vid.frame_start = frame_start_r;

endmodule
